// File: rtl/swerv_axi_ram_if.sv
// swerv_axi_ram_if: 64-bit AXI4 bus between a SweRV master port and the RAM slave
interface swerv_axi_ram_if #(parameter int ID_W = 4) ();
  logic            axi_awvalid, axi_awready, axi_awlock;
  logic [ID_W-1:0] axi_awid;
  logic [31:0]     axi_awaddr;
  logic [7:0]      axi_awlen;
  logic [2:0]      axi_awsize, axi_awprot;
  logic [1:0]      axi_awburst;
  logic [3:0]      axi_awregion, axi_awcache, axi_awqos;
  logic            axi_wvalid, axi_wready, axi_wlast;
  logic [63:0]     axi_wdata;
  logic [7:0]      axi_wstrb;
  logic            axi_bvalid, axi_bready;
  logic [1:0]      axi_bresp;
  logic [ID_W-1:0] axi_bid;
  logic            axi_arvalid, axi_arready, axi_arlock;
  logic [ID_W-1:0] axi_arid;
  logic [31:0]     axi_araddr;
  logic [7:0]      axi_arlen;
  logic [2:0]      axi_arsize, axi_arprot;
  logic [1:0]      axi_arburst;
  logic [3:0]      axi_arregion, axi_arcache, axi_arqos;
  logic            axi_rvalid, axi_rready, axi_rlast;
  logic [ID_W-1:0] axi_rid;
  logic [63:0]     axi_rdata;
  logic [1:0]      axi_rresp;
  modport master (
    output axi_awvalid, axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst,
           axi_awregion, axi_awlock, axi_awcache, axi_awprot, axi_awqos,
           axi_wvalid, axi_wdata, axi_wstrb, axi_wlast, axi_bready,
           axi_arvalid, axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
           axi_arregion, axi_arlock, axi_arcache, axi_arprot, axi_arqos, axi_rready,
    input  axi_awready, axi_wready, axi_bvalid, axi_bresp, axi_bid,
           axi_arready, axi_rvalid, axi_rid, axi_rdata, axi_rresp, axi_rlast
  );
  modport slave (
    input  axi_awvalid, axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst,
           axi_awregion, axi_awlock, axi_awcache, axi_awprot, axi_awqos,
           axi_wvalid, axi_wdata, axi_wstrb, axi_wlast, axi_bready,
           axi_arvalid, axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
           axi_arregion, axi_arlock, axi_arcache, axi_arprot, axi_arqos, axi_rready,
    output axi_awready, axi_wready, axi_bvalid, axi_bresp, axi_bid,
           axi_arready, axi_rvalid, axi_rid, axi_rdata, axi_rresp, axi_rlast
  );
endinterface

// File: rtl/swerv_axi_ram.sv
// swerv_axi_ram: AXI4 slave RAM with independent read and write FSMs over simple dual-port storage
module swerv_axi_ram #(
  parameter int          ID_W       = 4,
  parameter int          DEPTH_LOG2 = 14,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input logic clk,
  input logic rst_l,
  swerv_axi_ram_if.slave axi
);
  localparam int SH = DEPTH_LOG2 + 3;
  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  logic [63:0] r_mem [WORDS];
  w_state_t        r_wstate;
  logic [ID_W-1:0] r_wid, r_bid;
  logic [31:0]     r_woff;
  logic [7:0]      r_wlen, r_wcnt;
  logic            r_wfixed, r_werr, r_awready, r_wready, r_bvalid;
  logic [1:0]      r_bresp;
  logic            w_win, w_wfire, w_wlast_beat, w_wbeat_err;
  r_state_t        r_rstate;
  logic [ID_W-1:0] r_arid, r_rid;
  logic [31:0]     r_roff;
  logic [7:0]      r_rlen, r_rcnt;
  logic            r_rfixed, r_rberr, r_arready, r_rvalid, r_rlast;
  logic [1:0]      r_rresp;
  logic [63:0]     r_rdata;
  logic [31:0]     w_rsel;
  logic [7:0]      w_rcnt_n;
  logic            w_rin;
  logic [63:0]     w_rword;
  assign w_win        = (r_woff >> SH) == 32'd0;
  assign w_wfire      = r_wready && axi.axi_wvalid;
  assign w_wlast_beat = r_wcnt == r_wlen;
  assign w_wbeat_err  = !w_win || (axi.axi_wlast != w_wlast_beat);
  // Offset of the beat to load into the R output: next beat on a handshake, else the current one
  assign w_rsel   = (r_rvalid && !r_rfixed) ? r_roff + 32'd8 : r_roff;
  assign w_rcnt_n = r_rvalid ? r_rcnt + 8'd1 : r_rcnt;
  assign w_rin    = (w_rsel >> SH) == 32'd0;
  assign w_rword  = r_mem[w_rsel[SH-1:3]];
  assign axi.axi_awready = r_awready;
  assign axi.axi_wready  = r_wready;
  assign axi.axi_bvalid  = r_bvalid;
  assign axi.axi_bresp   = r_bresp;
  assign axi.axi_bid     = r_bid;
  assign axi.axi_arready = r_arready;
  assign axi.axi_rvalid  = r_rvalid;
  assign axi.axi_rid     = r_rid;
  assign axi.axi_rdata   = r_rdata;
  assign axi.axi_rresp   = r_rresp;
  assign axi.axi_rlast   = r_rlast;
  // Byte-enabled store of in-range W beats; contents survive reset
  always_ff @(posedge clk)
    if (w_wfire && w_win)
      for (int i = 0; i < 8; i++)
        if (axi.axi_wstrb[i]) r_mem[r_woff[SH-1:3]][8*i +: 8] <= axi.axi_wdata[8*i +: 8];
  // Write FSM: AW latch, W beats with sticky error, then B
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b1;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= OKAY;
      r_bid     <= '0;
      r_wid     <= '0;
      r_woff    <= '0;
      r_wlen    <= '0;
      r_wcnt    <= '0;
      r_wfixed  <= 1'b0;
      r_werr    <= 1'b0;
    end else
      case (r_wstate)
        W_IDLE: if (axi.axi_awvalid) begin
          r_wid     <= axi.axi_awid;
          r_woff    <= axi.axi_awaddr - BASE_ADDR;
          r_wlen    <= axi.axi_awlen;
          r_wcnt    <= '0;
          r_wfixed  <= axi.axi_awburst == 2'b00;
          r_werr    <= axi.axi_awburst[1];
          r_awready <= 1'b0;
          r_wready  <= 1'b1;
          r_wstate  <= W_DATA;
        end
        W_DATA: if (axi.axi_wvalid) begin
          r_werr <= r_werr || w_wbeat_err;
          if (w_wlast_beat) begin
            r_wready <= 1'b0;
            r_bvalid <= 1'b1;
            r_bid    <= r_wid;
            r_bresp  <= (r_werr || w_wbeat_err) ? SLVERR : OKAY;
            r_wstate <= W_RESP;
          end else begin
            r_wcnt <= r_wcnt + 8'd1;
            r_woff <= r_wfixed ? r_woff : r_woff + 32'd8;
          end
        end
        W_RESP: if (axi.axi_bready) begin
          r_bvalid  <= 1'b0;
          r_awready <= 1'b1;
          r_wstate  <= W_IDLE;
        end
        default: r_wstate <= W_IDLE;
      endcase
  // Read FSM: AR latch, one latency cycle, then stream beats holding outputs while stalled
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= OKAY;
      r_rid     <= '0;
      r_rdata   <= '0;
      r_arid    <= '0;
      r_roff    <= '0;
      r_rlen    <= '0;
      r_rcnt    <= '0;
      r_rfixed  <= 1'b0;
      r_rberr   <= 1'b0;
    end else
      case (r_rstate)
        R_IDLE: if (axi.axi_arvalid) begin
          r_arid    <= axi.axi_arid;
          r_roff    <= axi.axi_araddr - BASE_ADDR;
          r_rlen    <= axi.axi_arlen;
          r_rcnt    <= '0;
          r_rfixed  <= axi.axi_arburst == 2'b00;
          r_rberr   <= axi.axi_arburst[1];
          r_arready <= 1'b0;
          r_rstate  <= R_ADDR;
        end
        R_ADDR: r_rstate <= R_DATA;
        R_DATA: if (!r_rvalid || axi.axi_rready) begin
          if (r_rvalid && r_rlast) begin
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end else begin
            r_rvalid <= 1'b1;
            r_rid    <= r_arid;
            r_roff   <= w_rsel;
            r_rcnt   <= w_rcnt_n;
            r_rlast  <= w_rcnt_n == r_rlen;
            r_rdata  <= w_rin ? w_rword : '0;
            r_rresp  <= (!w_rin || r_rberr) ? SLVERR : OKAY;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
endmodule
